// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and stage count.
//   chunk_width()                  : bits handled by each pipeline stage.
//   stage_rec_t                    : per-stage pipeline record at the default
//                                    width (valid, partial sum, remaining
//                                    operands, carry, overflow, and the
//                                    subtract flag when PIPE_ADDER_SUB_EN is
//                                    defined).
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] psum;   // chunks summed so far; upper bits zero
    logic [DEFAULT_WIDTH-1:0] a;      // operand A, upper chunks still pending
    logic [DEFAULT_WIDTH-1:0] b;      // operand B (already inverted for subtract)
    logic                     carry;  // carry into the next chunk
    logic                     ovf;    // signed overflow of the chunk just summed
`ifdef PIPE_ADDER_SUB_EN
    logic                     sub;
`endif
  } stage_rec_t;

endpackage

// File: rtl/ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder, one instance per pipeline stage.
//   a, b  : chunk operands
//   ci    : carry into bit 0 of the chunk
//   sum   : chunk sum
//   co    : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (used for signed overflow)
module ripple_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple adder: sum = (a + b + cin) mod 2^WIDTH, split into STAGES
// chunks of WIDTH/STAGES bits with a register after each chunk. One beat per
// cycle throughput, latency STAGES cycles.
// Optional feature macro: PIPE_ADDER_SUB_EN adds a 'sub' input; sub=1 gives
// a - b (cin ignored, cout=1 means no borrow).
//
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   a, b, cin           : operands and carry-in (sub when the macro is set)
//   out_valid/out_ready : result beat handshake
//   sum, cout, ovf      : registered result, carry out, signed overflow
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both 1. Once valid is raised it holds, with its data, until
// that edge. in_ready depends only on out_valid/out_ready, never on in_valid.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be >= 1 and a multiple of STAGES");
  end

  // Same layout as adder_pkg::stage_rec_t, sized by WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic             ovf;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
`endif
  } stage_t;

  stage_t pipe [STAGES];
  stage_t nxt  [STAGES];
  stage_t in_rec;
  logic   adv;

  // The whole pipeline moves as one; it only stops when the result register
  // holds a beat the consumer is not taking.
  assign adv      = !pipe[STAGES-1].valid || out_ready;
  assign in_ready = adv;

  // Incoming beat as a stage record. Its carry field is the carry into
  // chunk 0; subtract is folded in here so every stage is a plain adder.
  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.a     = a;
`ifdef PIPE_ADDER_SUB_EN
    in_rec.b     = sub ? ~b : b;
    in_rec.carry = sub | cin;
    in_rec.sub   = sub;
`else
    in_rec.b     = b;
    in_rec.carry = cin;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nx;
    logic [CHUNK-1:0] csum;
    logic             co;
    logic             cm;

    if (k == 0) begin : g_first
      assign src = in_rec;
    end else begin : g_rest
      assign src = pipe[k-1];
    end

    ripple_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (src.a[k*CHUNK +: CHUNK]),
      .b    (src.b[k*CHUNK +: CHUNK]),
      .ci   (src.carry),
      .sum  (csum),
      .co   (co),
      .cmsb (cm)
    );

    // Everything passes through untouched except this stage's chunk of the
    // sum and the carry handed on to the next chunk. Only the last stage's
    // ovf reaches the output, where cm is the carry into the word MSB.
    always_comb begin
      nx                         = src;
      nx.psum[k*CHUNK +: CHUNK]  = csum;
      nx.carry                   = co;
      nx.ovf                     = co ^ cm;
    end

    assign nxt[k] = nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= nxt[i];
    end
  end

  assign out_valid = pipe[STAGES-1].valid;
  assign sum       = pipe[STAGES-1].psum;
  assign cout      = pipe[STAGES-1].carry;
  assign ovf       = pipe[STAGES-1].ovf;

endmodule
